fetch_unit: RTL and testbench

//  Instruction-fetch stage upstream of the decoder and directly driving the byte-addressable

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 22 ++
 rtl/fetch_queue.sv | 46 ++++
 rtl/fetch_unit.sv | 58 +++++
 tb/tb_fetch_unit.sv | 123 ++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and the queue entry type for the fetch stage.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: ROM port, redirect input and decode-side handshake of the fetch stage.
interface fetch_if #(parameter int MEM_DEPTH = 16);
    import fetch_pkg::*;
    logic [MEM_DEPTH-1:0] imem_addr;
    logic [INSTR_W-1:0]   imem_rdata;
    logic                 redirect_valid;
    logic [XLEN-1:0]      redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [XLEN-1:0]      out_pc;
    logic                 misalign_err;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, misalign_err,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, misalign_err,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of {pc, instr} entries; flush beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             data_i,
    output fetch_entry_t             data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + AW'(push_i);
        rd_d  = flush_i ? '0 : rd_q + AW'(pop_i);
        cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (push_i && !flush_i) mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, one ROM fetch per cycle into a small queue, redirect with flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              MEM_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              QDEPTH    = 2
) (
    input logic     clock,
    input logic     reset,
    fetch_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            push, pop, valid;
    logic [CW-1:0]   count;
    fetch_entry_t    entry, head;

    assign valid = count != '0;
    assign pop   = valid && bus.out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still fetch.
    assign push  = !bus.redirect_valid && (count != CW'(QDEPTH) || pop);
    assign entry = '{pc: pc_q, instr: bus.imem_rdata};

    always_comb begin
        pc_d  = bus.redirect_valid ? {bus.redirect_pc[XLEN-1:2], 2'b00} : push ? pc_q + PC_STEP : pc_q;
        err_d = err_q || (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .data_i  (entry),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.imem_addr    = pc_q[MEM_DEPTH-1:0];
    assign bus.out_valid    = valid;
    assign bus.out_pc       = head.pc;
    assign bus.out_instr    = head.instr;
    assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus checked against a queue-based model of the fetch stage.
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int MD = 16;
    localparam int QD = 2;
    localparam logic [31:0] RPC = 32'h0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fetch_if #(.MEM_DEPTH(MD)) bus();
    assign bus.imem_rdata = 32'h1000_0000 + 32'(bus.imem_addr >> 2);

    fetch_unit #(.MEM_DEPTH(MD), .RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_run = 0;
    int n_fail = 0;
    logic [63:0] mq[$];
    logic [31:0] mpc;
    logic        merr;

    function automatic logic [31:0] rom(logic [31:0] a);
        return 32'h1000_0000 + {18'b0, a[15:2]};
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs;
        check("imem_addr", 64'(bus.imem_addr), 64'(mpc[MD-1:0]));
        check("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("out_pc", 64'(bus.out_pc), 64'(mq[0][63:32]));
            check("out_instr", 64'(bus.out_instr), 64'(mq[0][31:0]));
        end
        check("misalign_err", 64'(bus.misalign_err), 64'(merr));
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop;
        int sz;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.out_ready = rdy;
        compare_outputs();
        sz = mq.size();
        pop = sz != 0 && rdy;
        if (rv) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) merr = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (sz < QD || pop) begin
                mq.push_back({mpc, rom(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_pc", 64'(bus.out_pc), 64'(0));
        check("rst_out_instr", 64'(bus.out_instr), 64'(0));
        check("rst_misalign", 64'(bus.misalign_err), 64'(0));
        mq.delete();
        mpc = RPC;
        merr = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic rv, rdy;
        logic [31:0] rpc;
        reset = 1'b0;
        #2;
        do_reset();
        repeat (8) step(1'b0, '0, 1'b1);
        repeat (5) step(1'b0, '0, 1'b0);
        repeat (6) step(1'b0, '0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h40, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h42, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        #2;
        do_reset();
        repeat (4) step(1'b0, '0, 1'b1);
        repeat (400) begin
            rv = $urandom_range(0, 11) == 0;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                              : {22'b0, 10'($urandom_range(0, 1023))};
            rdy = $urandom_range(0, 9) < 7;
            step(rv, rpc, rdy);
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
